// File: rtl/associate_bank.sv
// Bank of M trainable linear units sharing one N-element input vector.
// Forward pass yields M saturated sums; backward pass returns W^T*err and applies LMS.
module associate_bank #(
  parameter int N         = 2,
  parameter int M         = 2,
  parameter int ARG_WIDTH = 8,
  parameter int WGT_WIDTH = 16,
  parameter int RES_WIDTH = 16,
  parameter int ERR_WIDTH = 16,
  parameter int FBK_WIDTH = 16,
  parameter int RATE      = 0,
  parameter int SEED      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N*ARG_WIDTH-1:0] arg_data,
  input  logic                   arg_valid,
  output logic                   arg_ready,
  output logic [M*RES_WIDTH-1:0] res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  input  logic [M*ERR_WIDTH-1:0] err_data,
  input  logic                   err_valid,
  output logic                   err_ready,
  output logic [N*FBK_WIDTH-1:0] fbk_data,
  output logic                   fbk_valid,
  input  logic                   fbk_ready
);

  localparam int NW = N + 1;
  localparam int FA = WGT_WIDTH + ARG_WIDTH + $clog2(N + 2);
  localparam int BA = WGT_WIDTH + ERR_WIDTH + $clog2(M + 1);
  localparam int PW = ERR_WIDTH + ARG_WIDTH + 1;
  localparam int UW = (PW > WGT_WIDTH ? PW : WGT_WIDTH) + 1;
  localparam int CW = $clog2((N > M ? N : M) + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FWD, S_RES, S_HOLD, S_BWD, S_FBK
  } state_t;

  // Galois LFSR walk, one step per weight, unit-major order
  function automatic logic [M*NW*WGT_WIDTH-1:0] init_table();
    logic [15:0]                s;
    logic signed [15:0]         v;
    logic [M*NW*WGT_WIDTH-1:0]  t;
    s = 16'(SEED);
    t = '0;
    for (int k = 0; k < M * NW; k++) begin
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
      v = $signed(s) >>> 8;
      t[k*WGT_WIDTH +: WGT_WIDTH] = WGT_WIDTH'(v);
    end
    return t;
  endfunction

  localparam logic [M*NW*WGT_WIDTH-1:0] W_INIT = init_table();

  function automatic logic signed [RES_WIDTH-1:0] sat_res(
    input logic signed [FA-1:0] v
  );
    logic signed [FA-1:0] hi;
    logic signed [FA-1:0] lo;
    hi = FA'({1'b0, {(RES_WIDTH-1){1'b1}}});
    lo = ~hi;
    if (v > hi) return hi[RES_WIDTH-1:0];
    if (v < lo) return lo[RES_WIDTH-1:0];
    return v[RES_WIDTH-1:0];
  endfunction

  function automatic logic signed [FBK_WIDTH-1:0] sat_fbk(
    input logic signed [BA-1:0] v
  );
    logic signed [BA-1:0] hi;
    logic signed [BA-1:0] lo;
    hi = BA'({1'b0, {(FBK_WIDTH-1){1'b1}}});
    lo = ~hi;
    if (v > hi) return hi[FBK_WIDTH-1:0];
    if (v < lo) return lo[FBK_WIDTH-1:0];
    return v[FBK_WIDTH-1:0];
  endfunction

  function automatic logic signed [WGT_WIDTH-1:0] sat_wgt(
    input logic signed [UW-1:0] v
  );
    logic signed [UW-1:0] hi;
    logic signed [UW-1:0] lo;
    hi = UW'({1'b0, {(WGT_WIDTH-1){1'b1}}});
    lo = ~hi;
    if (v > hi) return hi[WGT_WIDTH-1:0];
    if (v < lo) return lo[WGT_WIDTH-1:0];
    return v[WGT_WIDTH-1:0];
  endfunction

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [ARG_WIDTH-1:0]         x_q [N];
  logic [ARG_WIDTH-1:0]         x_d [N];
  logic [ARG_WIDTH-1:0]         xa [NW];
  logic signed [ERR_WIDTH-1:0]  e_q [M];
  logic signed [ERR_WIDTH-1:0]  e_d [M];
  logic signed [FA-1:0]         acc_q [M];
  logic signed [FA-1:0]         acc_d [M];
  logic signed [BA-1:0]         fb_q [N];
  logic signed [BA-1:0]         fb_d [N];
  logic signed [WGT_WIDTH-1:0]  w_q [M][NW];
  logic signed [WGT_WIDTH-1:0]  w_d [M][NW];
  logic signed [RES_WIDTH-1:0]  res_q [M];
  logic signed [RES_WIDTH-1:0]  res_d [M];
  logic signed [FBK_WIDTH-1:0]  fbk_q [N];
  logic signed [FBK_WIDTH-1:0]  fbk_d [N];
  logic                         res_valid_q, res_valid_d;
  logic                         fbk_valid_q, fbk_valid_d;

  // bias input rides as the extra all-ones element
  always_comb begin
    for (int i = 0; i < N; i++) xa[i] = x_q[i];
    xa[N] = '1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    e_d         = e_q;
    acc_d       = acc_q;
    fb_d        = fb_q;
    w_d         = w_q;
    res_d       = res_q;
    fbk_d       = fbk_q;
    res_valid_d = res_valid_q;
    fbk_valid_d = fbk_valid_q;
    arg_ready   = 1'b0;
    err_ready   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        arg_ready = 1'b1;
        if (arg_valid) begin
          for (int i = 0; i < N; i++)
            x_d[i] = arg_data[i*ARG_WIDTH +: ARG_WIDTH];
          for (int j = 0; j < M; j++) acc_d[j] = '0;
          cnt_d   = '0;
          state_d = S_FWD;
        end
      end
      S_FWD: begin
        if (cnt_q == CW'(N + 1)) begin
          for (int j = 0; j < M; j++) res_d[j] = sat_res(acc_q[j]);
          res_valid_d = 1'b1;
          state_d     = S_RES;
        end else begin
          for (int j = 0; j < M; j++)
            for (int k = 0; k < NW; k++)
              if (cnt_q == CW'(k))
                acc_d[j] = acc_q[j] + FA'(w_q[j][k])
                         * $signed(FA'({1'b0, xa[k]}));
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RES: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        err_ready = 1'b1;
        arg_ready = !err_valid;
        if (err_valid) begin
          for (int j = 0; j < M; j++)
            e_d[j] = err_data[j*ERR_WIDTH +: ERR_WIDTH];
          for (int i = 0; i < N; i++) fb_d[i] = '0;
          cnt_d   = '0;
          state_d = S_BWD;
        end else if (arg_valid) begin
          for (int i = 0; i < N; i++)
            x_d[i] = arg_data[i*ARG_WIDTH +: ARG_WIDTH];
          for (int j = 0; j < M; j++) acc_d[j] = '0;
          cnt_d   = '0;
          state_d = S_FWD;
        end
      end
      S_BWD: begin
        if (cnt_q == CW'(M)) begin
          for (int i = 0; i < N; i++) fbk_d[i] = sat_fbk(fb_q[i]);
          fbk_valid_d = 1'b1;
          state_d     = S_FBK;
        end else begin
          // feedback reads w_q, so it always sees pre-update weights
          for (int j = 0; j < M; j++) begin
            if (cnt_q == CW'(j)) begin
              for (int i = 0; i < N; i++)
                fb_d[i] = fb_q[i] + BA'(w_q[j][i]) * BA'(e_q[j]);
              if (en)
                for (int i = 0; i < NW; i++)
                  w_d[j][i] = sat_wgt(UW'(w_q[j][i])
                    + ((UW'(e_q[j]) * $signed(UW'({1'b0, xa[i]})))
                       >>> RATE));
            end
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FBK: begin
        if (fbk_ready) begin
          fbk_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      fbk_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        x_q[i]   <= '0;
        fb_q[i]  <= '0;
        fbk_q[i] <= '0;
      end
      for (int j = 0; j < M; j++) begin
        e_q[j]   <= '0;
        acc_q[j] <= '0;
        res_q[j] <= '0;
        for (int i = 0; i < NW; i++)
          w_q[j][i] <= W_INIT[(j*NW+i)*WGT_WIDTH +: WGT_WIDTH];
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      fbk_valid_q <= fbk_valid_d;
      x_q         <= x_d;
      e_q         <= e_d;
      acc_q       <= acc_d;
      fb_q        <= fb_d;
      w_q         <= w_d;
      res_q       <= res_d;
      fbk_q       <= fbk_d;
    end
  end

  assign res_valid = res_valid_q;
  assign fbk_valid = fbk_valid_q;

  for (genvar j = 0; j < M; j++) begin : g_res
    assign res_data[j*RES_WIDTH +: RES_WIDTH] = res_q[j];
  end
  for (genvar i = 0; i < N; i++) begin : g_fbk
    assign fbk_data[i*FBK_WIDTH +: FBK_WIDTH] = fbk_q[i];
  end

endmodule

// File: tb/tb_associate_bank.sv
// Directed bench for associate_bank: handshakes, latency, stalls,
// AND/OR training to fixed weights, feedback and async reset.
module tb_associate_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] arg_data = '0;
  logic        arg_valid = 1'b0;
  logic        arg_ready;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] err_data = '0;
  logic        err_valid = 1'b0;
  logic        err_ready;
  logic [31:0] fbk_data;
  logic        fbk_valid;
  logic        fbk_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  associate_bank #(.RATE(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .arg_data(arg_data), .arg_valid(arg_valid), .arg_ready(arg_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .err_data(err_data), .err_valid(err_valid), .err_ready(err_ready),
    .fbk_data(fbk_data), .fbk_valid(fbk_valid), .fbk_ready(fbk_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic fwd(input logic [15:0] a, input int stall,
                     output int r0, output int r1,
                     output int lat, output logic ar_seen);
    int n;
    logic [31:0] hold;
    arg_data = a;
    arg_valid = 1'b1;
    n = 0;
    while (!arg_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("arg_accept", int'(arg_ready), 1);
    @(posedge clk); #1;
    arg_valid = 1'b0;
    lat = 0;
    ar_seen = 1'b0;
    while (!res_valid && lat < 50) begin
      if (arg_ready) ar_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    chk("res_valid_seen", int'(res_valid), 1);
    r0 = s16(res_data[15:0]);
    r1 = s16(res_data[31:16]);
    hold = res_data;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_res_valid", int'(res_valid), 1);
      chk("stall_res_data", int'(res_data == hold), 1);
      chk("stall_arg_ready", int'(arg_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic bwd(input int e0, input int e1, input int stall,
                     output int f0, output int f1, output int lat);
    int n;
    logic [31:0] hold;
    err_data = {16'(e1), 16'(e0)};
    err_valid = 1'b1;
    n = 0;
    while (!err_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("err_accept", int'(err_ready), 1);
    @(posedge clk); #1;
    err_valid = 1'b0;
    lat = 0;
    while (!fbk_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("fbk_valid_seen", int'(fbk_valid), 1);
    f0 = s16(fbk_data[15:0]);
    f1 = s16(fbk_data[31:16]);
    hold = fbk_data;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_fbk_valid", int'(fbk_valid), 1);
      chk("stall_fbk_data", int'(fbk_data == hold), 1);
      chk("stall_err_ready", int'(err_ready), 0);
    end
    fbk_ready = 1'b1;
    @(posedge clk); #1;
    fbk_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] arg;
    int          tand;
    int          tor;
    int          r0;
    int          r1;
  } vec_t;

  vec_t tv[4];

  initial begin
    int   r0, r1, lat, f0, f1, e0, e1;
    logic seen;
    // trained AND unit: w=(251,506,-514); OR unit: w=(254,254,-2)
    tv[0] = '{16'h0000, 0,   0,   -32768, -510};
    tv[1] = '{16'h00ff, 0,   255, -32768, 32767};
    tv[2] = '{16'hff00, 0,   255, -2040,  32767};
    tv[3] = '{16'hffff, 255, 255, 32767,  32767};

    #12;
    chk("rst_arg_ready", int'(arg_ready), 1);
    chk("rst_err_ready", int'(err_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_fbk_valid", int'(fbk_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_fbk_data", int'(fbk_data), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    fwd(16'h0000, 0, r0, r1, lat, seen);
    chk("t1_latency", lat, 4);
    chk("t1_arg_ready_low", int'(seen), 0);
    chk("t1_res0", r0, 0);
    chk("t1_res1", r1, 0);

    en = 1'b1;
    bwd(0, 0, 0, f0, f1, lat);
    chk("t2_latency", lat, 3);
    chk("t2_fbk0", f0, 0);
    chk("t2_fbk1", f1, 0);
    fwd(16'hffff, 0, r0, r1, lat, seen);
    chk("t2_res0", r0, 0);
    chk("t2_res1", r1, 0);

    fwd(16'h1234, 10, r0, r1, lat, seen);
    chk("t3_res0", r0, 0);
    bwd(0, 0, 10, f0, f1, lat);
    chk("t3_fbk0", f0, 0);

    en = 1'b1;
    for (int ep = 0; ep < 25; ep++) begin
      for (int p = 0; p < 4; p++) begin
        fwd(tv[p].arg, 0, r0, r1, lat, seen);
        e0 = tv[p].tand - (r0 < 0 ? 0 : 255);
        e1 = tv[p].tor - (r1 < 0 ? 0 : 255);
        bwd(e0, e1, 0, f0, f1, lat);
      end
    end

    en = 1'b0;
    for (int p = 0; p < 4; p++) begin
      fwd(tv[p].arg, 0, r0, r1, lat, seen);
      chk($sformatf("t4_res0_p%0d", p), r0, tv[p].r0);
      chk($sformatf("t4_res1_p%0d", p), r1, tv[p].r1);
      chk($sformatf("t4_err0_p%0d", p), tv[p].tand - (r0 < 0 ? 0 : 255), 0);
      chk($sformatf("t4_err1_p%0d", p), tv[p].tor - (r1 < 0 ? 0 : 255), 0);
    end

    bwd(16, 16, 0, f0, f1, lat);
    chk("t5_latency", lat, 3);
    chk("t5_fbk0", f0, 8080);
    chk("t5_fbk1", f1, 12160);
    fwd(16'hff00, 0, r0, r1, lat, seen);
    chk("t5_res0", r0, -2040);
    chk("t5_res1", r1, 32767);

    err_data = '0;
    err_valid = 1'b1;
    @(posedge clk); #1;
    err_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_res_valid", int'(res_valid), 0);
    chk("t6_fbk_valid", int'(fbk_valid), 0);
    chk("t6_arg_ready", int'(arg_ready), 1);
    chk("t6_err_ready", int'(err_ready), 0);
    chk("t6_res_data", int'(res_data), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    fwd(16'hffff, 0, r0, r1, lat, seen);
    chk("t6_latency", lat, 4);
    chk("t6_res0", r0, 0);
    chk("t6_res1", r1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
